// File: rtl/noc_flit_injector.sv
// Transmit end of the credit-based router link: serialises AXI-Stream beats
// into flits and issues one flit per cycle only while a downstream credit is held.
module noc_flit_injector #(
    parameter int TDATA_WIDTH          = 128,
    parameter int SERIALIZATION_FACTOR = 2,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int DEST_WIDTH           = 6,
    parameter int FLIT_BUFFER_DEPTH    = 8,
    parameter int CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    input  logic                    axis_tvalid,
    output logic                    axis_tready,
    input  logic [TDATA_WIDTH-1:0]  axis_tdata,
    input  logic                    axis_tlast,
    input  logic [DEST_WIDTH-1:0]   axis_tdest,
    output logic [FLIT_WIDTH-1:0]   data_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    output logic                    is_tail_out,
    output logic                    send_out,
    input  logic                    credit_in,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_overflow
);

    localparam int IDX_WIDTH = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam logic [IDX_WIDTH-1:0]    LAST_IDX     = IDX_WIDTH'(SERIALIZATION_FACTOR - 1);
    localparam logic [CREDIT_WIDTH-1:0] FULL_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    typedef enum logic {IDLE, SERIALIZE} state_t;

    state_t                  state, state_next;
    logic                    buf_valid;
    logic [TDATA_WIDTH-1:0]  buf_data;
    logic [DEST_WIDTH-1:0]   buf_dest;
    logic                    buf_last;
    logic [IDX_WIDTH-1:0]    flit_idx;
    logic                    issue, last_issue, accept;
    logic [CREDIT_WIDTH-1:0] credit_next;
    logic                    overflow_hit;

    assign buf_valid = (state == SERIALIZE);

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) state <= IDLE;
        else              state <= state_next;
    end

    // A new beat may land in the same cycle the previous one drains its last flit.
    always_comb begin
        state_next = state;
        if (accept)          state_next = SERIALIZE;
        else if (last_issue) state_next = IDLE;
    end

    always_comb begin
        issue       = buf_valid && (credit_count != '0);
        last_issue  = issue && (flit_idx == LAST_IDX);
        axis_tready = !rst_noc_sync && (!buf_valid || last_issue);
        accept      = axis_tvalid && axis_tready;
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            send_out    <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
            buf_data    <= '0;
            buf_dest    <= '0;
            buf_last    <= 1'b0;
            flit_idx    <= '0;
        end else begin
            send_out <= issue;
            if (issue) begin
                data_out    <= buf_data[int'(flit_idx) * FLIT_WIDTH +: FLIT_WIDTH];
                dest_out    <= buf_dest;
                is_tail_out <= buf_last && (flit_idx == LAST_IDX);
                flit_idx    <= (flit_idx == LAST_IDX) ? '0 : flit_idx + 1'b1;
            end
            if (accept) begin
                buf_data <= axis_tdata;
                buf_dest <= axis_tdest;
                buf_last <= axis_tlast;
                flit_idx <= '0;
            end
        end
    end

    // A credit returned while already full cannot be stored: saturate and flag it.
    always_comb begin
        credit_next  = credit_count;
        overflow_hit = 1'b0;
        if (issue && !credit_in) begin
            credit_next = credit_count - 1'b1;
        end else if (credit_in && !issue) begin
            if (credit_count == FULL_CREDITS) overflow_hit = 1'b1;
            else                              credit_next  = credit_count + 1'b1;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            credit_count    <= FULL_CREDITS;
            credit_overflow <= 1'b0;
        end else begin
            credit_count <= credit_next;
            if (overflow_hit) credit_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_flit_injector.sv
// Bench for noc_flit_injector: a queue-of-flits reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_noc_flit_injector;

    localparam int TW    = 128;
    localparam int SF    = 2;
    localparam int FW    = TW / SF;
    localparam int DW    = 6;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          axis_tvalid = 1'b0;
    logic          axis_tready;
    logic [TW-1:0] axis_tdata = '0;
    logic          axis_tlast = 1'b0;
    logic [DW-1:0] axis_tdest = '0;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic          credit_in = 1'b0;
    logic [CW-1:0] credit_count;
    logic          credit_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_flit_injector #(
        .TDATA_WIDTH(TW),
        .SERIALIZATION_FACTOR(SF),
        .DEST_WIDTH(DW),
        .FLIT_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_noc(clk),
        .rst_noc_sync(rst),
        .axis_tvalid(axis_tvalid),
        .axis_tready(axis_tready),
        .axis_tdata(axis_tdata),
        .axis_tlast(axis_tlast),
        .axis_tdest(axis_tdest),
        .data_out(data_out),
        .dest_out(dest_out),
        .is_tail_out(is_tail_out),
        .send_out(send_out),
        .credit_in(credit_in),
        .credit_count(credit_count),
        .credit_overflow(credit_overflow)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    // Reference model: queue of flits still owed by the held beat, plain credit integer.
    typedef struct {
        logic [FW-1:0] data;
        logic [DW-1:0] dest;
        logic          tail;
    } flit_t;

    flit_t         mq[$];
    int            m_cred = DEPTH;
    bit            m_ovf = 0;
    bit            m_send = 0;
    logic [FW-1:0] m_data = '0;
    logic [DW-1:0] m_dest = '0;
    bit            m_tail = 0;
    bit            chk_en = 0;

    always @(negedge clk) begin
        flit_t f;
        bit    m_issue;
        bit    m_tready;
        m_tready = !rst && (mq.size() == 0 || (mq.size() == 1 && m_cred > 0));
        if (chk_en) begin
            chk("send_out", send_out, m_send);
            chk("data_out", data_out, m_data);
            chk("dest_out", dest_out, m_dest);
            chk("is_tail_out", is_tail_out, m_tail);
            chk("credit_count", credit_count, m_cred);
            chk("credit_overflow", credit_overflow, m_ovf);
            chk("axis_tready", axis_tready, m_tready);
        end
        if (rst) begin
            mq.delete();
            m_cred = DEPTH; m_ovf = 0; m_send = 0;
            m_data = '0; m_dest = '0; m_tail = 0;
            chk_en = 1;
        end else begin
            m_issue = (mq.size() > 0) && (m_cred > 0);
            if (m_issue) begin
                f = mq.pop_front();
                m_send = 1; m_data = f.data; m_dest = f.dest; m_tail = f.tail;
            end else begin
                m_send = 0;
            end
            if (m_issue && !credit_in) m_cred--;
            else if (credit_in && !m_issue) begin
                if (m_cred == DEPTH) m_ovf = 1;
                else m_cred++;
            end
            if (axis_tvalid && m_tready) begin
                for (int k = 0; k < SF; k++) begin
                    f.data = axis_tdata[k*FW +: FW];
                    f.dest = axis_tdest;
                    f.tail = axis_tlast && (k == SF - 1);
                    mq.push_back(f);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a beat and returns just after the edge that accepted it; tvalid stays high.
    task automatic send_beat(input logic [TW-1:0] d, input logic [DW-1:0] dst, input logic last);
        bit acc = 0;
        axis_tdata  = d;
        axis_tdest  = dst;
        axis_tlast  = last;
        axis_tvalid = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = axis_tready;
            tick();
        end
        if (!acc) chk("beat_accept_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [TW-1:0] pat;
        pat = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;

        repeat (2) tick();
        chk("rst_send", send_out, 1'b0);
        chk("rst_data", data_out, '0);
        chk("rst_dest", dest_out, '0);
        chk("rst_tail", is_tail_out, 1'b0);
        chk("rst_credit", credit_count, 8);
        chk("rst_ovf", credit_overflow, 1'b0);
        chk("rst_tready", axis_tready, 1'b0);
        rst = 1'b0;
        #1 chk("idle_tready", axis_tready, 1'b1);

        // Single tlast beat: LSB flit first, tail only on the second flit.
        send_beat(pat, 6'h2A, 1'b1);
        axis_tvalid = 1'b0;
        chk("t1_send0", send_out, 1'b0);
        tick();
        chk("t1_send1", send_out, 1'b1);
        chk("t1_data1", data_out, 64'h5555_5555_5555_5555);
        chk("t1_dest1", dest_out, 6'h2A);
        chk("t1_tail1", is_tail_out, 1'b0);
        chk("t1_cred1", credit_count, 7);
        tick();
        chk("t1_send2", send_out, 1'b1);
        chk("t1_data2", data_out, 64'hAAAA_AAAA_AAAA_AAAA);
        chk("t1_dest2", dest_out, 6'h2A);
        chk("t1_tail2", is_tail_out, 1'b1);
        chk("t1_cred2", credit_count, 6);
        tick();
        chk("t1_idle_send", send_out, 1'b0);
        chk("t1_hold_data", data_out, 64'hAAAA_AAAA_AAAA_AAAA);

        // Refill to full, then one extra credit overflows and sticks.
        credit_in = 1'b1;
        repeat (2) tick();
        chk("refill_cred", credit_count, 8);
        chk("refill_ovf", credit_overflow, 1'b0);
        tick();
        credit_in = 1'b0;
        chk("ovf_set", credit_overflow, 1'b1);
        chk("ovf_cred", credit_count, 8);
        repeat (3) tick();
        chk("ovf_sticky", credit_overflow, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared", credit_overflow, 1'b0);

        // Back-to-back stream until credits run out, then one-credit release.
        for (int i = 0; i < 5; i++) send_beat({$urandom, $urandom, $urandom, $urandom}, DW'(i), 1'b0);
        axis_tvalid = 1'b0;
        repeat (3) tick();
        chk("stall_cred", credit_count, 0);
        chk("stall_send", send_out, 1'b0);
        chk("stall_tready", axis_tready, 1'b0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        chk("cin_no_send", send_out, 1'b0);
        chk("cin_cred", credit_count, 1);
        tick();
        chk("cin_send", send_out, 1'b1);
        chk("cin_cred_used", credit_count, 0);
        tick();
        chk("cin_stall_again", send_out, 1'b0);
        credit_in = 1'b1;
        repeat (3) tick();
        credit_in = 1'b0;

        // Reset after the first flit drops the rest of the beat.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_beat(pat, 6'h15, 1'b1);
        axis_tvalid = 1'b0;
        tick();
        chk("mid_first_flit", send_out, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_send", send_out, 1'b0);
        chk("mid_rst_cred", credit_count, 8);
        chk("mid_rst_tready", axis_tready, 1'b0);
        rst = 1'b0;
        tick();
        chk("mid_no_second", send_out, 1'b0);
        tick();
        chk("mid_still_idle", send_out, 1'b0);

        repeat (3000) begin
            rst         = ($urandom_range(0, 199) == 0);
            axis_tvalid = ($urandom_range(0, 9) < 7);
            axis_tdata  = {$urandom, $urandom, $urandom, $urandom};
            axis_tdest  = DW'($urandom);
            axis_tlast  = 1'($urandom);
            credit_in   = ($urandom_range(0, 9) < 4);
            tick();
        end
        axis_tvalid = 1'b0;
        credit_in   = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
